// File: rtl/main_memory.sv
// main_memory
//   Block-transfer memory responder for the memory side of cache_controller.
//   It accepts level-held block read/write requests and waits a fixed latency.
//   Each request completes with a single-cycle mem_ready pulse.
//   After every reset the array is filled with an address-derived pattern:
//   word w of block b = {16'hC0DE, (b*BLOCK_WORDS + w)[15:0]}.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   mem_re     in   block read request (held until mem_ready)
//   mem_we     in   block write request (held until mem_ready, wins over mem_re)
//   mem_addr   in   word address; block index = addr[OFF+IDX-1:OFF], upper bits alias
//   mem_wdata  in   write block, word w at [32w+31:32w]
//   mem_rdata  out  read block, same packing, held until the next read completes
//   mem_ready  out  one-cycle completion pulse
//   mem_busy   out  registered, high in every state except IDLE
module main_memory #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BLOCK_WORDS  = 4,
  parameter int DEPTH_BLOCKS = 64,
  parameter int LATENCY      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_re,
  input  logic                      mem_we,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [32*BLOCK_WORDS-1:0] mem_wdata,
  output logic [32*BLOCK_WORDS-1:0] mem_rdata,
  output logic                      mem_ready,
  output logic                      mem_busy
);

  localparam int BLK_W = 32 * BLOCK_WORDS;
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(DEPTH_BLOCKS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_BLK  = IDX_W'(DEPTH_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_blk_q, init_blk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic             ready_q;
  logic [BLK_W-1:0] rdata_q;

  // Request fields captured at acceptance; no reset needed since they are
  // only consumed after a fresh acceptance.
  logic             req_we_q;
  logic [IDX_W-1:0] req_blk_q;
  logic [BLK_W-1:0] req_wdata_q;

  logic [BLK_W-1:0] mem_q [DEPTH_BLOCKS];

  logic accept;
  logic commit;
  logic init_wr;

  // Only the index field of the address is decoded; the offset and upper
  // bits are intentionally ignored, which makes addresses alias.
  logic unused_addr;
  assign unused_addr = ^mem_addr;

  function automatic logic [BLK_W-1:0] init_pattern(input logic [IDX_W-1:0] blk);
    logic [BLK_W-1:0] v;
    logic [31:0]      idx;
    v = '0;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      idx = 32'(blk) * 32'(BLOCK_WORDS) + 32'(w);
      v[32*w +: 32] = {16'hC0DE, idx[15:0]};
    end
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    init_blk_d = init_blk_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    commit     = 1'b0;
    init_wr    = 1'b0;
    case (state_q)
      S_INIT: begin
        init_wr    = 1'b1;
        init_blk_d = init_blk_q + 1'b1;
        if (init_blk_q == LAST_BLK) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (mem_re || mem_we) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: state_d = S_RELEASE;
      // A request still held after completion must not start a second
      // transaction, so wait for both request lines to drop.
      S_RELEASE: begin
        if (!mem_re && !mem_we) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_blk_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_blk_q <= init_blk_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != S_IDLE);
      ready_q    <= commit;
      if (commit && !req_we_q) rdata_q <= mem_q[req_blk_q];
    end
  end

  // Write wins over read when both are requested together.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_q    <= mem_we;
      req_blk_q   <= mem_addr[OFF_W +: IDX_W];
      req_wdata_q <= mem_wdata;
    end
  end

  // A write that reaches its commit edge together with reset is dropped;
  // INIT then rewrites the whole array anyway.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem_q[init_blk_q] <= init_pattern(init_blk_q);
    end else if (commit && req_we_q && !reset) begin
      mem_q[req_blk_q] <= req_wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory
//   Directed bench for main_memory with default parameters
//   (BLOCK_WORDS=4, DEPTH_BLOCKS=64, LATENCY=4).
module tb_main_memory;

  logic         clk;
  logic         reset;
  logic         mem_re;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         mem_busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] P0 = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
  localparam logic [127:0] P1 = 128'hC0DE0007_C0DE0006_C0DE0005_C0DE0004;
  localparam logic [127:0] P2 = 128'hC0DE000B_C0DE000A_C0DE0009_C0DE0008;
  localparam logic [127:0] PA = {4{32'hAAAAAAAA}};
  localparam logic [127:0] P5 = {4{32'h55555555}};
  localparam logic [127:0] PF = {4{32'hFFFFFFFF}};

  main_memory #(
    .ADDR_WIDTH  (16),
    .BLOCK_WORDS (4),
    .DEPTH_BLOCKS(64),
    .LATENCY     (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_busy (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (mem_busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {127'd0, mem_busy}, 128'd0);
  endtask

  // Issue one request from IDLE, measure edges from acceptance to mem_ready,
  // then drop the request and wait for IDLE again.
  task automatic txn(input logic re, input logic we, input logic [15:0] addr,
                     input logic [127:0] wd, input string tag);
    int n;
    @(negedge clk);
    mem_re = re; mem_we = we; mem_addr = addr; mem_wdata = wd;
    @(posedge clk); #1;
    n = 0;
    while (mem_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd4);
    @(negedge clk);
    mem_re = 1'b0; mem_we = 1'b0;
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b1; mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {127'd0, mem_busy},  128'd1);
    check("rst_ready", {127'd0, mem_ready}, 128'd0);
    check("rst_rdata", mem_rdata, 128'd0);

    // INIT takes 64 edges, busy falls on the edge entering IDLE
    @(negedge clk); reset = 1'b0;
    n = 0;
    while (mem_busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_edges", 128'(n), 128'd64);

    // Basic reads and aliasing
    txn(1'b1, 1'b0, 16'd0, '0, "rd0");
    check("rd0_data", mem_rdata, P0);
    txn(1'b1, 1'b0, 16'd9, '0, "rd9");
    check("rd9_data", mem_rdata, P2);
    txn(1'b1, 1'b0, 16'd256, '0, "rd256");
    check("rd256_data", mem_rdata, P0);

    // Write block 0, rdata must not change on a write
    txn(1'b0, 1'b1, 16'd2, PA, "wr2");
    check("wr2_rdata_hold", mem_rdata, P0);
    txn(1'b1, 1'b0, 16'd1, '0, "rd1");
    check("rd1_data", mem_rdata, PA);
    txn(1'b1, 1'b0, 16'd4, '0, "rd4");
    check("rd4_data", mem_rdata, P1);

    // Request held 12 cycles gives exactly one pulse
    @(negedge clk);
    mem_re = 1'b1; mem_addr = 16'd9;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) pulses++;
    end
    @(negedge clk);
    mem_re = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) pulses++;
    end
    check("hold_pulses", 128'(pulses), 128'd1);
    check("hold_data", mem_rdata, P2);
    wait_idle("hold_idle");

    // Read and write together: the write wins
    txn(1'b1, 1'b1, 16'd8, P5, "rw8");
    check("rw8_rdata_hold", mem_rdata, P2);
    txn(1'b1, 1'b0, 16'd8, '0, "rd8");
    check("rd8_data", mem_rdata, P5);

    // Request held through INIT is accepted on the first IDLE edge (65),
    // ready follows 4 edges later (69)
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst2_busy", {127'd0, mem_busy}, 128'd1);
    @(negedge clk);
    reset = 1'b0; mem_re = 1'b1; mem_addr = 16'd9;
    n = 0;
    while (mem_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_req_edges", 128'(n), 128'd69);
    check("init_req_data", mem_rdata, P2);
    @(negedge clk); mem_re = 1'b0;
    wait_idle("init_req_idle");
    txn(1'b1, 1'b0, 16'd8, '0, "rd8_restored");
    check("rd8_restored_data", mem_rdata, P2);

    // Reset sampled at E0+2 of a write: no ready, write dropped
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 16'd0; mem_wdata = PF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1; mem_we = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) pulses++;
    end
    check("midrst_pulses", 128'(pulses), 128'd0);
    check("midrst_busy", {127'd0, mem_busy}, 128'd1);
    @(negedge clk); reset = 1'b0;
    wait_idle("midrst_idle");
    txn(1'b1, 1'b0, 16'd0, '0, "midrst_rd0");
    check("midrst_rd0_data", mem_rdata, P0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
